// File: rtl/wave_gen_pkg.sv
// Shared waveform codes, DAC width and the elaboration-time quarter-sine generator.
// Imported by the generator, its ROM and the DAC frame stage.
package wave_gen_pkg;

    localparam int DAC_W  = 12;
    localparam int LUT_DW = 11;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'b00,
        WAVE_SQR = 2'b01,
        WAVE_TRI = 2'b10,
        WAVE_SIN = 2'b11
    } wave_t;

    // Entry idx of a 2^aw-point quarter sine scaled to 0..2047; entry 0 is exactly 0.
    function automatic logic [LUT_DW-1:0] qsine_entry(input int idx, input int aw);
        real x;
        real term;
        real sum;
        real v;
        x    = (3.14159265358979 / 2.0) * real'(idx) / real'(1 << aw);
        sum  = x;
        term = x;
        for (int k = 1; k < 8; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        v = sum * 2047.0 + 0.5;
        if (v > 2047.0) v = 2047.0;
        if (v < 0.0) v = 0.0;
        return LUT_DW'($rtoi(v));
    endfunction

endpackage

// File: rtl/wave_gen_if.sv
// Control and sample bus between the waveform generator and its user.
// master drives the controls and takes samples; slave is the generator side.
interface wave_gen_if
    import wave_gen_pkg::*;
#(
    parameter int PHASE_W = 24
);
    logic               en;
    logic               phase_rst;
    logic [PHASE_W-1:0] freq_word;
    wave_t              wave_sel;
    logic [DAC_W-1:0]   data;
    logic               data_valid;

    modport master (
        output en, phase_rst, freq_word, wave_sel,
        input  data, data_valid
    );

    modport slave (
        input  en, phase_rst, freq_word, wave_sel,
        output data, data_valid
    );
endinterface

// File: rtl/wave_gen_sine_qlut.sv
// Quarter-wave sine ROM, contents computed at elaboration; synchronous read, 1-cycle latency.
module wave_gen_sine_qlut
    import wave_gen_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    output logic [LUT_DW-1:0] data
);
    localparam int DEPTH = 1 << AW;

    logic [LUT_DW-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [LUT_DW-1:0] ENTRY = qsine_entry(i, AW);
        assign rom[i] = ENTRY;
    end

    always_ff @(posedge clk) begin
        data <= rom[addr];
    end
endmodule

// File: rtl/wave_gen.sv
// DDS sample source: tick-stepped phase accumulator, saw/square/triangle/sine shaper, 2-edge latency.
// SINE_LUT_EN builds the quarter-wave ROM; without it wave_sel=11 falls back to triangle.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_DIV = 64,
    parameter int LUT_AW     = 8
) (
    input logic        clk,
    input logic        rst,
    wave_gen_if.slave  bus
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    if (PHASE_W < 14 || SAMPLE_DIV < 2 || LUT_AW < 1 || LUT_AW > 10) begin : g_bad_param
        $error("wave_gen: illegal parameter combination");
    end

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [PHASE_W-1:0] phase;
    logic [DAC_W-1:0]   p_cur;
    wave_t              sel_q;
    logic               s1_vld;
    logic [DAC_W-1:0]   s2_p;
    wave_t              s2_sel;
    logic               s2_vld;
    logic [DAC_W-1:0]   tri_val;
    logic [DAC_W-1:0]   sin_val;
    logic [DAC_W-1:0]   shape;

    assign tick  = bus.en && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign p_cur = phase[PHASE_W-1 -: DAC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!bus.en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Phase clear wins over the increment, yet a coincident tick still launches a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= '0;
            sel_q  <= WAVE_SAW;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= tick;
            if (bus.phase_rst) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase + bus.freq_word;
            end
            if (tick) begin
`ifdef SINE_LUT_EN
                sel_q <= bus.wave_sel;
`else
                sel_q <= (bus.wave_sel == WAVE_SIN) ? WAVE_TRI : bus.wave_sel;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_p   <= '0;
            s2_sel <= WAVE_SAW;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_p   <= p_cur;
                s2_sel <= sel_q;
            end
        end
    end

    assign tri_val = s2_p[11] ? ~{s2_p[10:0], 1'b0} : {s2_p[10:0], 1'b0};

`ifdef SINE_LUT_EN
    logic [LUT_AW-1:0] lut_addr;
    logic [LUT_DW-1:0] lut_q;

    // Odd quadrants walk the quarter table backwards; ROM output lines up with s2_p.
    assign lut_addr = p_cur[9 -: LUT_AW] ^ {LUT_AW{p_cur[10]}};

    wave_gen_sine_qlut #(
        .AW   (LUT_AW)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .data (lut_q)
    );

    // 0x800 + 2047 tops out at 0xFFF, so the upper half never needs saturation.
    assign sin_val = s2_p[11] ? (12'h7FF - {1'b0, lut_q}) : (12'h800 + {1'b0, lut_q});
`else
    assign sin_val = tri_val;
`endif

    always_comb begin
        shape = s2_p;
        case (s2_sel)
            WAVE_SAW: shape = s2_p;
            WAVE_SQR: shape = s2_p[11] ? 12'hFFF : 12'h000;
            WAVE_TRI: shape = tri_val;
            default:  shape = sin_val;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= s2_vld;
            if (s2_vld) begin
                bus.data <= shape;
            end
        end
    end
endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen: reset, each waveform, phase clear on tick, wave_sel and en timing.
module tb_wave_gen;
    import wave_gen_pkg::*;

    localparam int PW  = 24;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wave_gen_if #(.PHASE_W(PW)) bus();

    wave_gen #(
        .PHASE_W    (PW),
        .SAMPLE_DIV (DIV),
        .LUT_AW     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_vld(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.data_valid && gap < 200);
    endtask

    task automatic expect_sample(input string tag, input logic [11:0] exp, input int exp_gap);
        int gap;
        wait_vld(gap);
        check({tag, "_vld"}, 32'(bus.data_valid), 32'd1);
        if (exp_gap > 0) check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
        check(tag, 32'(bus.data), 32'(exp));
    endtask

    task automatic pulse_phase_rst();
        bus.phase_rst = 1'b1;
        @(negedge clk);
        bus.phase_rst = 1'b0;
    endtask

    task automatic count_vld(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.data_valid) cnt++;
        end
    endtask

    logic [11:0] sqr_tab [16] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                                  12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                                  12'hFFF, 12'h000};
    logic [11:0] tri_tab [16] = '{12'h200, 12'h400, 12'h600, 12'h800, 12'hA00, 12'hC00, 12'hE00,
                                  12'hFFF, 12'hDFF, 12'hBFF, 12'h9FF, 12'h7FF, 12'h5FF, 12'h3FF,
                                  12'h1FF, 12'h000};
`ifdef SINE_LUT_EN
    logic [11:0] sin_tab [4] = '{12'hFFF, 12'h7FF, 12'h000, 12'h800};
`else
    logic [11:0] sin_tab [4] = '{12'h800, 12'hFFF, 12'h7FF, 12'h000};
`endif

    initial begin
        int cnt;
        int gap;

        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.phase_rst = 1'b0;
        bus.freq_word = 24'h100000;
        bus.wave_sel  = WAVE_SAW;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_vld", 32'(bus.data_valid), 32'h0);

        rst    = 1'b0;
        bus.en = 1'b1;
        expect_sample("saw0", 12'h100, DIV + 2);
        for (int i = 1; i < 17; i++) begin
            expect_sample($sformatf("saw%0d", i), 12'((i + 1) * 256), DIV);
        end

        bus.wave_sel = WAVE_SQR;
        pulse_phase_rst();
        for (int i = 0; i < 16; i++) begin
            expect_sample($sformatf("sqr%0d", i), sqr_tab[i], (i == 0) ? 3 : DIV);
        end

        bus.wave_sel = WAVE_TRI;
        pulse_phase_rst();
        for (int i = 0; i < 16; i++) begin
            expect_sample($sformatf("tri%0d", i), tri_tab[i], (i == 0) ? 3 : DIV);
        end

        // wave_sel changed after the tick: the in-flight sample keeps triangle.
        repeat (2) @(negedge clk);
        bus.wave_sel = WAVE_SAW;
        expect_sample("sel_inflight", 12'h200, 2);
        expect_sample("sel_next", 12'h200, DIV);

        // phase clear on the tick edge yields wave(0).
        @(negedge clk);
        bus.phase_rst = 1'b1;
        @(negedge clk);
        bus.phase_rst = 1'b0;
        expect_sample("prst_tick", 12'h000, 2);
        expect_sample("prst_after", 12'h100, DIV);

        // async reset with a sample in flight.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_data", 32'(bus.data), 32'h0);
        check("rst_mid_vld", 32'(bus.data_valid), 32'h0);
        count_vld(4, cnt);
        check("rst_discard", 32'(cnt), 32'h0);
        rst = 1'b0;
        expect_sample("rst_first", 12'h100, DIV + 2);

        // en dropped between ticks.
        bus.en = 1'b0;
        count_vld(12, cnt);
        check("en_hold_vld", 32'(cnt), 32'h0);
        check("en_hold_data", 32'(bus.data), 32'h100);
        bus.en = 1'b1;
        expect_sample("en_resume", 12'h200, DIV + 2);

        // en dropped with a sample in flight.
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        expect_sample("en_inflight", 12'h300, 2);
        count_vld(10, cnt);
        check("en_off_vld", 32'(cnt), 32'h0);
        bus.en = 1'b1;
        expect_sample("en_resume2", 12'h400, DIV + 2);

        bus.wave_sel  = WAVE_SIN;
        bus.freq_word = 24'h040000;
        pulse_phase_rst();
        for (int k = 0; k < 64; k++) begin
            if (k % 16 == 15) begin
                expect_sample($sformatf("sin%0d", k), sin_tab[k / 16], DIV);
            end else begin
                wait_vld(gap);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
